hazard_scoreboard: RTL and testbench

Parametrised load-use/RAW hazard unit for the pipelined CPU. It tracks every in-flight register writer in a small age-ordered shift tracker with per-entry result latency, and stalls the instruction in ID only while one of its source registers is still unavailable. It sits beside the ID stage, driving the PC, IF/ID and ID/EX control registers. It generalises the single-cycle load-use check to:

- configurable load and ALU latencies;
- a forwarding-off mode;
- memory freeze and branch flush;
- a stall performance counter.

---
 rtl/hazard_scoreboard.sv | 116 +++++++++++
 tb/tb_hazard_scoreboard.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// RAW/load-use hazard unit: tracks in-flight register writers in an age-ordered shift tracker
// and stalls the ID instruction while any of its sources is still unavailable.
module hazard_scoreboard #(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned MAX_LAT     = 4,
    parameter int unsigned LOAD_LAT    = 1,
    parameter int unsigned ALU_LAT     = 0,
    parameter int unsigned ZERO_REG_EN = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              IF_ID_Valid_i,
    input  logic [ADDR_W-1:0] IF_ID_RegisterRs_i,
    input  logic [ADDR_W-1:0] IF_ID_RegisterRt_i,
    input  logic              IF_ID_RsUsed_i,
    input  logic              IF_ID_RtUsed_i,
    input  logic              IF_ID_RegWrite_i,
    input  logic              IF_ID_MemRead_i,
    input  logic [ADDR_W-1:0] IF_ID_RegisterRd_i,
    input  logic              Mem_Stall_i,
    input  logic              Flush_i,
    output logic              PC_Write_o,
    output logic              IF_ID_Write_o,
    output logic              ID_EX_Bubble_o,
    output logic              Hazard_o,
    output logic [CNT_W-1:0]  Stall_Cnt_o
);

    localparam int unsigned LAT_W = $clog2(MAX_LAT + 1);
    localparam logic [LAT_W-1:0] LoadLat = LAT_W'(LOAD_LAT);
    localparam logic [LAT_W-1:0] AluLat  = LAT_W'(ALU_LAT);
    localparam bit ZeroRegEn = (ZERO_REG_EN != 0);

    logic [MAX_LAT-1:0] valid_q, valid_d;
    logic [ADDR_W-1:0]  rd_q  [MAX_LAT];
    logic [ADDR_W-1:0]  rd_d  [MAX_LAT];
    logic [LAT_W-1:0]   lat_q [MAX_LAT];
    logic [LAT_W-1:0]   lat_d [MAX_LAT];
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic rs_hit, rt_hit, hazard, bubble_cycle, insert;

    // An entry at stage j still blocks readers only while its latency exceeds its age.
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        for (int j = 0; j < int'(MAX_LAT); j++) begin
            if (valid_q[j] && (lat_q[j] > LAT_W'(j))) begin
                if (IF_ID_RsUsed_i && (rd_q[j] == IF_ID_RegisterRs_i)) rs_hit = 1'b1;
                if (IF_ID_RtUsed_i && (rd_q[j] == IF_ID_RegisterRt_i)) rt_hit = 1'b1;
            end
        end
        if (ZeroRegEn && (IF_ID_RegisterRs_i == '0)) rs_hit = 1'b0;
        if (ZeroRegEn && (IF_ID_RegisterRt_i == '0)) rt_hit = 1'b0;
        hazard = IF_ID_Valid_i && (rs_hit || rt_hit);
    end

    always_comb begin
        PC_Write_o     = 1'b1;
        IF_ID_Write_o  = 1'b1;
        ID_EX_Bubble_o = 1'b0;
        bubble_cycle   = 1'b0;
        if (Mem_Stall_i) begin
            PC_Write_o    = 1'b0;
            IF_ID_Write_o = 1'b0;
        end else if (Flush_i) begin
            ID_EX_Bubble_o = 1'b1;
        end else if (hazard) begin
            PC_Write_o     = 1'b0;
            IF_ID_Write_o  = 1'b0;
            ID_EX_Bubble_o = 1'b1;
            bubble_cycle   = 1'b1;
        end
    end

    assign insert = IF_ID_Valid_i && IF_ID_RegWrite_i && !Flush_i && !hazard;

    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        lat_d   = lat_q;
        cnt_d   = cnt_q;
        if (!Mem_Stall_i) begin
            for (int k = 1; k < int'(MAX_LAT); k++) begin
                valid_d[k] = valid_q[k-1];
                rd_d[k]    = rd_q[k-1];
                lat_d[k]   = lat_q[k-1];
            end
            valid_d[0] = insert;
            rd_d[0]    = IF_ID_RegisterRd_i;
            lat_d[0]   = IF_ID_MemRead_i ? LoadLat : AluLat;
        end
        if (bubble_cycle && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < int'(MAX_LAT); k++) begin
                rd_q[k]  <= '0;
                lat_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            lat_q   <= lat_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Hazard_o    = hazard;
    assign Stall_Cnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three differently configured instances share one ID stimulus
// stream; directed table vectors plus random traffic checked against a countdown model.
module tb_hazard_scoreboard;

    typedef struct {
        logic       rst_n, valid, rs_used, rt_used, regwrite, memread, mem_stall, flush;
        logic [4:0] rs, rt, rd;
    } in_t;

    typedef struct {
        in_t  in;
        bit   chk;
        logic pc, ifid, bub, haz;
        int   cnt_a;
        logic haz_b;
        int   cnt_b;
    } vec_t;

    logic clk = 1'b0;
    in_t  cur;

    logic [2:0]  d_pc, d_ifid, d_bub, d_haz;
    logic [15:0] cnt_a, cnt_b;
    logic [1:0]  cnt_c;

    int n_chk = 0;
    int n_err = 0;

    // Per-instance configuration: {LOAD_LAT, ALU_LAT, ZERO_REG_EN, counter max}
    int p_load [3] = '{1, 3, 2};
    int p_alu  [3] = '{0, 2, 1};
    int p_zero [3] = '{1, 1, 0};
    int p_cmax [3] = '{65535, 65535, 3};

    // Model: each pending writer is a slot holding rd and the cycles until its result is usable.
    int m_rd  [3][16];
    int m_rem [3][16];
    int m_cnt [3];
    bit m_init = 1'b0;

    vec_t tbl[$];

    always #5 clk = ~clk;

    hazard_scoreboard u_dut_a (
        .clk_i(clk), .rst_i(cur.rst_n), .IF_ID_Valid_i(cur.valid),
        .IF_ID_RegisterRs_i(cur.rs), .IF_ID_RegisterRt_i(cur.rt),
        .IF_ID_RsUsed_i(cur.rs_used), .IF_ID_RtUsed_i(cur.rt_used),
        .IF_ID_RegWrite_i(cur.regwrite), .IF_ID_MemRead_i(cur.memread),
        .IF_ID_RegisterRd_i(cur.rd), .Mem_Stall_i(cur.mem_stall), .Flush_i(cur.flush),
        .PC_Write_o(d_pc[0]), .IF_ID_Write_o(d_ifid[0]), .ID_EX_Bubble_o(d_bub[0]),
        .Hazard_o(d_haz[0]), .Stall_Cnt_o(cnt_a)
    );

    hazard_scoreboard #(.LOAD_LAT(3), .ALU_LAT(2)) u_dut_b (
        .clk_i(clk), .rst_i(cur.rst_n), .IF_ID_Valid_i(cur.valid),
        .IF_ID_RegisterRs_i(cur.rs), .IF_ID_RegisterRt_i(cur.rt),
        .IF_ID_RsUsed_i(cur.rs_used), .IF_ID_RtUsed_i(cur.rt_used),
        .IF_ID_RegWrite_i(cur.regwrite), .IF_ID_MemRead_i(cur.memread),
        .IF_ID_RegisterRd_i(cur.rd), .Mem_Stall_i(cur.mem_stall), .Flush_i(cur.flush),
        .PC_Write_o(d_pc[1]), .IF_ID_Write_o(d_ifid[1]), .ID_EX_Bubble_o(d_bub[1]),
        .Hazard_o(d_haz[1]), .Stall_Cnt_o(cnt_b)
    );

    hazard_scoreboard #(.LOAD_LAT(2), .ALU_LAT(1), .ZERO_REG_EN(0), .CNT_W(2)) u_dut_c (
        .clk_i(clk), .rst_i(cur.rst_n), .IF_ID_Valid_i(cur.valid),
        .IF_ID_RegisterRs_i(cur.rs), .IF_ID_RegisterRt_i(cur.rt),
        .IF_ID_RsUsed_i(cur.rs_used), .IF_ID_RtUsed_i(cur.rt_used),
        .IF_ID_RegWrite_i(cur.regwrite), .IF_ID_MemRead_i(cur.memread),
        .IF_ID_RegisterRd_i(cur.rd), .Mem_Stall_i(cur.mem_stall), .Flush_i(cur.flush),
        .PC_Write_o(d_pc[2]), .IF_ID_Write_o(d_ifid[2]), .ID_EX_Bubble_o(d_bub[2]),
        .Hazard_o(d_haz[2]), .Stall_Cnt_o(cnt_c)
    );

    function automatic in_t f_nop();
        in_t i;
        i = '{rst_n: 1'b1, valid: 1'b0, rs_used: 1'b0, rt_used: 1'b0, regwrite: 1'b0,
              memread: 1'b0, mem_stall: 1'b0, flush: 1'b0, rs: 5'd0, rt: 5'd0, rd: 5'd0};
        return i;
    endfunction

    function automatic in_t f_ld(input int rd);
        in_t i;
        i = f_nop();
        i.valid = 1'b1; i.regwrite = 1'b1; i.memread = 1'b1; i.rd = 5'(rd);
        return i;
    endfunction

    function automatic in_t f_alu(input int rs, input bit rsu, input int rt, input bit rtu,
                                  input int rd);
        in_t i;
        i = f_nop();
        i.valid = 1'b1; i.regwrite = 1'b1; i.rd = 5'(rd);
        i.rs = 5'(rs); i.rs_used = rsu; i.rt = 5'(rt); i.rt_used = rtu;
        return i;
    endfunction

    task automatic add(input in_t i, input bit c, input logic pc, input logic ifid,
                       input logic bub, input logic haz, input int ca, input logic hb,
                       input int cb);
        vec_t v;
        v.in = i; v.chk = c; v.pc = pc; v.ifid = ifid; v.bub = bub; v.haz = haz;
        v.cnt_a = ca; v.haz_b = hb; v.cnt_b = cb;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_haz(input int d, input in_t i);
        bit h = 1'b0;
        for (int s = 0; s < 16; s++) begin
            if (m_rem[d][s] > 0) begin
                if (i.rs_used && m_rd[d][s] == int'(i.rs) && !(p_zero[d] != 0 && i.rs == 0))
                    h = 1'b1;
                if (i.rt_used && m_rd[d][s] == int'(i.rt) && !(p_zero[d] != 0 && i.rt == 0))
                    h = 1'b1;
            end
        end
        return h && i.valid;
    endfunction

    task automatic m_clock(input in_t i);
        for (int d = 0; d < 3; d++) begin
            if (!i.rst_n) begin
                for (int s = 0; s < 16; s++) m_rem[d][s] = 0;
                m_cnt[d] = 0;
            end else if (!i.mem_stall) begin
                bit h;
                int lat;
                h = m_haz(d, i);
                for (int s = 0; s < 16; s++) if (m_rem[d][s] > 0) m_rem[d][s]--;
                if (!i.flush && h && m_cnt[d] < p_cmax[d]) m_cnt[d]++;
                if (i.valid && i.regwrite && !i.flush && !h) begin
                    lat = i.memread ? p_load[d] : p_alu[d];
                    if (lat > 0) begin
                        for (int s = 0; s < 16; s++) begin
                            if (m_rem[d][s] == 0) begin
                                m_rem[d][s] = lat;
                                m_rd[d][s]  = int'(i.rd);
                                break;
                            end
                        end
                    end
                end
            end
        end
        if (!i.rst_n) m_init = 1'b1;
    endtask

    task automatic step(input in_t i, input vec_t v);
        int dcnt [3];
        cur = i;
        #4;
        dcnt[0] = int'(cnt_a); dcnt[1] = int'(cnt_b); dcnt[2] = int'(cnt_c);
        if (m_init) begin
            for (int d = 0; d < 3; d++) begin
                bit h, epc, eif, ebub;
                h = m_haz(d, i);
                epc = 1'b1; eif = 1'b1; ebub = 1'b0;
                if (i.mem_stall) begin
                    epc = 1'b0; eif = 1'b0;
                end else if (i.flush) begin
                    ebub = 1'b1;
                end else if (h) begin
                    epc = 1'b0; eif = 1'b0; ebub = 1'b1;
                end
                check($sformatf("model dut%0d haz", d), int'(d_haz[d]), int'(h));
                check($sformatf("model dut%0d pc_write", d), int'(d_pc[d]), int'(epc));
                check($sformatf("model dut%0d ifid_write", d), int'(d_ifid[d]), int'(eif));
                check($sformatf("model dut%0d bubble", d), int'(d_bub[d]), int'(ebub));
                check($sformatf("model dut%0d stall_cnt", d), dcnt[d], m_cnt[d]);
            end
        end
        if (v.chk) begin
            check("vec dut_a pc_write", int'(d_pc[0]), int'(v.pc));
            check("vec dut_a ifid_write", int'(d_ifid[0]), int'(v.ifid));
            check("vec dut_a bubble", int'(d_bub[0]), int'(v.bub));
            check("vec dut_a haz", int'(d_haz[0]), int'(v.haz));
            check("vec dut_a stall_cnt", dcnt[0], v.cnt_a);
            check("vec dut_b haz", int'(d_haz[1]), int'(v.haz_b));
            check("vec dut_b stall_cnt", dcnt[1], v.cnt_b);
        end
        @(posedge clk);
        m_clock(i);
        #1;
    endtask

    initial begin
        in_t  i;
        vec_t none;
        none = '{in: f_nop(), chk: 1'b0, pc: 1'b0, ifid: 1'b0, bub: 1'b0, haz: 1'b0,
                 cnt_a: 0, haz_b: 1'b0, cnt_b: 0};
        cur = f_nop();
        cur.rst_n = 1'b0;

        // Reset, then load->use on both latency configs
        i = f_nop(); i.rst_n = 1'b0;
        add(i, 1'b0, 1, 1, 0, 0, 0, 0, 0);
        add(f_nop(), 1'b1, 1, 1, 0, 0, 0, 0, 0);
        add(f_ld(5), 1'b1, 1, 1, 0, 0, 0, 0, 0);
        add(f_alu(5, 1, 6, 1, 9), 1'b1, 0, 0, 1, 1, 0, 1, 0);
        add(f_alu(5, 1, 6, 1, 9), 1'b1, 1, 1, 0, 0, 1, 1, 1);
        add(f_alu(5, 1, 6, 1, 9), 1'b1, 1, 1, 0, 0, 1, 1, 2);
        add(f_alu(5, 1, 6, 1, 9), 1'b1, 1, 1, 0, 0, 1, 0, 3);
        // ALU latency 2 on dut_b; register 0 never blocks
        add(f_alu(9, 1, 0, 0, 10), 1'b1, 1, 1, 0, 0, 1, 1, 3);
        add(f_alu(9, 1, 0, 0, 10), 1'b1, 1, 1, 0, 0, 1, 1, 4);
        add(f_alu(9, 1, 0, 0, 10), 1'b1, 1, 1, 0, 0, 1, 0, 5);
        add(f_alu(0, 0, 0, 0, 0), 1'b1, 1, 1, 0, 0, 1, 0, 5);
        add(f_alu(0, 1, 11, 1, 12), 1'b1, 1, 1, 0, 0, 1, 0, 5);
        // Freeze for 4 cycles with rs == rt dependent pending
        add(f_ld(4), 1'b1, 1, 1, 0, 0, 1, 0, 5);
        i = f_alu(4, 1, 4, 1, 13); i.mem_stall = 1'b1;
        for (int n = 0; n < 4; n++) add(i, 1'b1, 0, 0, 0, 1, 1, 1, 5);
        add(f_alu(4, 1, 4, 1, 13), 1'b1, 0, 0, 1, 1, 1, 1, 5);
        add(f_alu(4, 1, 4, 1, 13), 1'b1, 1, 1, 0, 0, 2, 1, 6);
        // Flush beats hazard
        add(f_ld(4), 1'b1, 1, 1, 0, 0, 2, 0, 7);
        i = f_alu(4, 1, 0, 0, 14); i.flush = 1'b1;
        add(i, 1'b1, 1, 1, 1, 1, 2, 1, 7);
        add(f_alu(20, 1, 21, 1, 22), 1'b1, 1, 1, 0, 0, 2, 0, 7);
        // Reset in the middle of dut_b's three-cycle stall
        add(f_ld(7), 1'b1, 1, 1, 0, 0, 2, 0, 7);
        add(f_alu(0, 0, 7, 1, 23), 1'b1, 0, 0, 1, 1, 2, 1, 7);
        i = f_alu(0, 0, 7, 1, 23); i.rst_n = 1'b0;
        add(i, 1'b1, 1, 1, 0, 0, 3, 1, 8);
        add(f_alu(0, 0, 7, 1, 23), 1'b1, 1, 1, 0, 0, 0, 0, 0);
        add(f_nop(), 1'b1, 1, 1, 0, 0, 0, 0, 0);

        @(posedge clk);
        #1;
        foreach (tbl[n]) step(tbl[n].in, tbl[n]);

        for (int n = 0; n < 3000; n++) begin
            i = f_nop();
            i.rst_n     = ($urandom_range(0, 149) != 0);
            i.valid     = ($urandom_range(0, 7) != 0);
            i.rs        = 5'($urandom_range(0, 7));
            i.rt        = 5'($urandom_range(0, 7));
            i.rd        = 5'($urandom_range(0, 7));
            i.rs_used   = 1'($urandom_range(0, 1));
            i.rt_used   = 1'($urandom_range(0, 1));
            i.regwrite  = ($urandom_range(0, 3) != 0);
            i.memread   = 1'($urandom_range(0, 1));
            i.mem_stall = ($urandom_range(0, 9) == 0);
            i.flush     = ($urandom_range(0, 9) == 0);
            step(i, none);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
